// File: rtl/traffic_pkg.sv
// Light encodings shared by the traffic sensor and the light controller.
package traffic_pkg;

  localparam logic [2:0] LIGHT_GREEN  = 3'b100;
  localparam logic [2:0] LIGHT_RED    = 3'b010;
  localparam logic [2:0] LIGHT_YELLOW = 3'b001;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == LIGHT_GREEN) || (v == LIGHT_RED) || (v == LIGHT_YELLOW);
  endfunction

endpackage

// File: rtl/lane_queue.sv
// One street: synchronizer, optional debounce (TRAFFIC_SENSOR_DEBOUNCE_EN), edge detect,
// saturating car counter and the departure timer that drains it while green.
module lane_queue
  import traffic_pkg::*;
#(
  parameter int unsigned QUEUE_W         = 4,
  parameter int unsigned PASS_CYCLES     = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               car,
  input  logic               green,
  input  logic               freeze,
  output logic [QUEUE_W-1:0] count,
  output logic               present
);

  localparam int unsigned TIMER_W = (PASS_CYCLES > 1) ? $clog2(PASS_CYCLES) : 1;
  localparam logic [QUEUE_W-1:0] COUNT_MAX = '1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PASS_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level;
  logic                   prev_q;
  logic                   arrival_q;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic [QUEUE_W-1:0]     count_q, count_d;
  logic                   running;
  logic                   depart;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], car};
    end
  end

`ifdef TRAFFIC_SENSOR_DEBOUNCE_EN
  localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic             deb_q;
  logic [DEB_W-1:0] deb_cnt_q;

  // Level flips only after the synced input has disagreed for DEBOUNCE_CYCLES in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
    end else if (sync_q[SYNC_STAGES-1] != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_q     <= sync_q[SYNC_STAGES-1];
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + DEB_W'(1);
      end
    end else begin
      deb_cnt_q <= '0;
    end
  end

  assign level = deb_q;
`else
  logic unused_debounce;
  assign unused_debounce = ^DEBOUNCE_CYCLES;
  assign level = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q    <= 1'b0;
      arrival_q <= 1'b0;
      timer_q   <= '0;
      count_q   <= '0;
    end else begin
      prev_q    <= level;
      arrival_q <= level & ~prev_q;
      timer_q   <= timer_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    running = green && (count_q != '0) && !freeze;
    depart  = running && (timer_q == TIMER_LAST);
    timer_d = '0;
    if (running && !depart) begin
      timer_d = timer_q + TIMER_W'(1);
    end
    count_d = count_q;
    // Simultaneous arrival and departure cancel, also at empty and full.
    if (arrival_q && !depart && (count_q != COUNT_MAX)) begin
      count_d = count_q + QUEUE_W'(1);
    end else if (depart && !arrival_q) begin
      count_d = count_q - QUEUE_W'(1);
    end
  end

  assign count   = count_q;
  assign present = |count_q;

endmodule

// File: rtl/traffic_sensor.sv
// Two car queues fed by arrival buttons and drained on green, plus a sticky illegal-light flag.
// Optional debounce on the buttons is enabled by defining TRAFFIC_SENSOR_DEBOUNCE_EN.
module traffic_sensor
  import traffic_pkg::*;
#(
  parameter int unsigned QUEUE_W         = 4,
  parameter int unsigned PASS_CYCLES     = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               car_a,
  input  logic               car_b,
  input  logic [2:0]         LA,
  input  logic [2:0]         LB,
  output logic               TA,
  output logic               TB,
  output logic [QUEUE_W-1:0] count_a,
  output logic [QUEUE_W-1:0] count_b,
  output logic               fault
);

  logic fault_q;
  logic illegal;

  // Both streets showing anything but red at once is as bad as a malformed code.
  assign illegal = !is_onehot3(LA) || !is_onehot3(LB) ||
                   ((LA != LIGHT_RED) && (LB != LIGHT_RED));

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (illegal) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;

  lane_queue #(
    .QUEUE_W        (QUEUE_W),
    .PASS_CYCLES    (PASS_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_lane_a (
    .clk    (clk),
    .reset  (reset),
    .car    (car_a),
    .green  (LA == LIGHT_GREEN),
    .freeze (fault_q),
    .count  (count_a),
    .present(TA)
  );

  lane_queue #(
    .QUEUE_W        (QUEUE_W),
    .PASS_CYCLES    (PASS_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_lane_b (
    .clk    (clk),
    .reset  (reset),
    .car    (car_b),
    .green  (LB == LIGHT_GREEN),
    .freeze (fault_q),
    .count  (count_b),
    .present(TB)
  );

endmodule

// File: tb/tb_traffic_sensor.sv
// Bench for traffic_sensor: directed scenarios plus random lights/buttons, checked every cycle
// against a delay-line/queue model of the arrival, drain and fault rules.
module tb_traffic_sensor;

  localparam int QW   = 4;
  localparam int PASS = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int QMAX = (1 << QW) - 1;
`ifdef TRAFFIC_SENSOR_DEBOUNCE_EN
  localparam int LAT = SYNC + 1 + DEB;
  localparam int PH  = DEB + 2;
`else
  localparam int LAT = SYNC + 1;
  localparam int PH  = 2;
`endif
  localparam int CAR_I   = (PASS - 1 - LAT > 0) ? PASS - 1 - LAT : 0;
  localparam int GREEN_I = (LAT + 1 - PASS > 0) ? LAT + 1 - PASS : 0;

  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] R = 3'b010;
  localparam logic [2:0] Y = 3'b001;

  logic          clk = 1'b0;
  logic          reset, car_a, car_b;
  logic [2:0]    LA, LB;
  logic          TA, TB, fault;
  logic [QW-1:0] count_a, count_b;

  int checks = 0;
  int failures = 0;

  traffic_sensor #(
    .QUEUE_W        (QW),
    .PASS_CYCLES    (PASS),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .car_a  (car_a),
    .car_b  (car_b),
    .LA     (LA),
    .LB     (LB),
    .TA     (TA),
    .TB     (TB),
    .count_a(count_a),
    .count_b(count_b),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_hist[2][16];  // button samples, [0] = newest edge
  int m_lvl[2][4];    // conditioned button level after each edge
  int m_deb[2], m_diff[2], m_streak[2], m_cnt[2];
  int m_fault;
  bit model_valid = 1'b0;

  function automatic bit legal_code(input logic [2:0] v);
    return (v == G) || (v == R) || (v == Y);
  endfunction

  initial begin
    int carv, arr, dep, grn, run;
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int s = 0; s < 2; s++) begin
          for (int j = 0; j < 16; j++) m_hist[s][j] = 0;
          for (int j = 0; j < 4; j++) m_lvl[s][j] = 0;
          m_deb[s] = 0; m_diff[s] = 0; m_streak[s] = 0; m_cnt[s] = 0;
        end
        m_fault = 0;
        model_valid = 1'b1;
      end else if (model_valid) begin
        for (int s = 0; s < 2; s++) begin
          carv = (s == 0) ? int'(car_a) : int'(car_b);
          grn  = (s == 0) ? int'(LA == G) : int'(LB == G);
          for (int j = 15; j > 0; j--) m_hist[s][j] = m_hist[s][j-1];
          m_hist[s][0] = carv;
          for (int j = 3; j > 0; j--) m_lvl[s][j] = m_lvl[s][j-1];
`ifdef TRAFFIC_SENSOR_DEBOUNCE_EN
          if (m_hist[s][SYNC] != m_deb[s]) begin
            m_diff[s]++;
            if (m_diff[s] == DEB) begin
              m_deb[s] = m_hist[s][SYNC];
              m_diff[s] = 0;
            end
          end else begin
            m_diff[s] = 0;
          end
          m_lvl[s][0] = m_deb[s];
`else
          m_lvl[s][0] = m_hist[s][SYNC-1];
`endif
          arr = (m_lvl[s][2] == 1 && m_lvl[s][3] == 0) ? 1 : 0;
          run = (grn == 1 && m_cnt[s] != 0 && m_fault == 0) ? 1 : 0;
          m_streak[s] = run ? m_streak[s] + 1 : 0;
          dep = (run == 1 && (m_streak[s] % PASS) == 0) ? 1 : 0;
          if (arr == 1 && dep == 0 && m_cnt[s] < QMAX) m_cnt[s]++;
          else if (dep == 1 && arr == 0) m_cnt[s]--;
        end
        if (!legal_code(LA) || !legal_code(LB) || (LA != R && LB != R)) m_fault = 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (model_valid) begin
        check("count_a", count_a, m_cnt[0]);
        check("count_b", count_b, m_cnt[1]);
        check("TA", TA, (m_cnt[0] != 0));
        check("TB", TB, (m_cnt[1] != 0));
        check("fault", fault, m_fault);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic after_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_car(input int s, input logic v);
    if (s == 0) car_a = v;
    else car_b = v;
  endtask

  task automatic press(input int s, input int hi, input int lo);
    set_car(s, 1'b1);
    tick(hi);
    set_car(s, 1'b0);
    tick(lo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lcnt, r;
    reset = 1'b1; car_a = 1'b0; car_b = 1'b0; LA = R; LB = G;
    after_edges(2);
    check("rst_count_a", count_a, 0);
    check("rst_TA", TA, 0);
    check("rst_fault", fault, 0);
    tick(1);
    reset = 1'b0;

    // Three arrivals on A while A is red.
    for (int i = 0; i < 3; i++) press(0, PH, PH);
    tick(LAT);
    check("three_a", count_a, 3);
    check("three_a_model", m_cnt[0], 3);
    check("three_a_TA", TA, 1);
    check("three_b_zero", count_b, 0);
    check("three_TB", TB, 0);

    // Drain on green: one car every PASS cycles.
    LA = G; LB = R;
    after_edges(PASS); check("drain_2", count_a, 2);
    after_edges(PASS); check("drain_1", count_a, 1);
    after_edges(PASS); check("drain_0", count_a, 0);
    check("drain_TA", TA, 0);
    check("drain_model", m_cnt[0], 0);
    tick(1);

    // Saturation on B.
    LA = R; LB = R;
    for (int i = 0; i < 17; i++) press(1, PH, PH);
    tick(LAT);
    check("sat_b", count_b, QMAX);
    check("sat_b_model", m_cnt[1], QMAX);
    check("sat_TB", TB, 1);

    // Arrival landing on the departure cycle at count 1.
    press(0, PH, PH);
    tick(LAT);
    check("one_a", count_a, 1);
    if (CAR_I <= GREEN_I) begin
      car_a = 1'b1; tick(GREEN_I - CAR_I); LA = G;
      after_edges(PASS);
    end else begin
      LA = G; tick(CAR_I - GREEN_I); car_a = 1'b1;
      after_edges(LAT + 1);
    end
    check("same_cycle_1", count_a, 1);
    check("same_cycle_model", m_cnt[0], 1);
    tick(1);
    car_a = 1'b0;
    tick(2 * PASS + PH);
    check("green_empty", count_a, 0);
    car_a = 1'b1;
    after_edges(LAT + 1);
    check("arrive_at_0", count_a, 1);
    tick(1);
    car_a = 1'b0;
    tick(PH + 2 * PASS + 2);

    // Fault: sticky, freezes departures, arrivals still counted.
    LA = R; LB = R;
    for (int i = 0; i < 3; i++) press(0, PH, PH);
    tick(LAT);
    check("pre_fault_a", count_a, 3);
    LA = G; LB = Y;
    after_edges(1);
    check("fault_set", fault, 1);
    tick(1);
    LB = R;
    tick(3 * PASS);
    check("fault_sticky", fault, 1);
    check("fault_frozen", count_a, 3);
    press(0, PH, PH);
    tick(LAT);
    check("fault_arrival", count_a, 4);
    check("fault_arrival_model", m_cnt[0], 4);
    reset = 1'b1;
    after_edges(1);
    check("reset_fault", fault, 0);
    check("reset_count_a", count_a, 0);
    check("reset_count_b", count_b, 0);
    tick(1);
    reset = 1'b0;
    LA = R; LB = R;

`ifdef TRAFFIC_SENSOR_DEBOUNCE_EN
    car_a = 1'b1; tick(3); car_a = 1'b0;
    tick(LAT + 5);
    check("glitch_ignored", count_a, 0);
    car_a = 1'b1;
    after_edges(SYNC + DEB + 1);
    check("deb_not_yet", count_a, 0);
    after_edges(1);
    check("deb_counted", count_a, 1);
    tick(20 - SYNC - DEB - 2);
    car_a = 1'b0;
    tick(LAT + 4);
`endif

    // Random phase.
    lcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (lcnt == 0) begin
        r = $urandom_range(0, 99);
        if (r < 2) begin
          LA = 3'($urandom_range(0, 7)); LB = 3'($urandom_range(0, 7));
        end else begin
          case ($urandom_range(0, 4))
            0: begin LA = G; LB = R; end
            1: begin LA = Y; LB = R; end
            2: begin LA = R; LB = R; end
            3: begin LA = R; LB = G; end
            default: begin LA = R; LB = Y; end
          endcase
        end
        lcnt = $urandom_range(1, 20);
      end else begin
        lcnt--;
      end
`ifdef TRAFFIC_SENSOR_DEBOUNCE_EN
      if ($urandom_range(0, 11) == 0) car_a = ~car_a;
      if ($urandom_range(0, 11) == 0) car_b = ~car_b;
`else
      if ($urandom_range(0, 3) == 0) car_a = ~car_a;
      if ($urandom_range(0, 3) == 0) car_b = ~car_b;
`endif
      reset = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
